amiga_kbd_arbiter: RTL

AMIGA_KBD_ARBITER -- requirements
Module: amiga_kbd_arbiter

---
 rtl/amiga_kbd_arbiter_pkg.sv | 21 ++
 rtl/amiga_kbd_arbiter_fifo.sv | 44 ++++
 rtl/amiga_kbd_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/amiga_kbd_arbiter_pkg.sv
// Shared definitions for the Amiga keyboard arbiter: FSM states, power-up codes
// and the serial byte encoding (rotate left one bit, then invert).
package amiga_kbd_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ACK,
    ST_GAP
  } kbd_state_e;

  localparam logic [7:0] KBD_CODE_INIT = 8'hFD;
  localparam logic [7:0] KBD_CODE_TERM = 8'hFE;
  localparam int         GAP_TICKS     = 64;

  function automatic logic [7:0] kbd_encode(input logic [7:0] raw);
    return ~{raw[6:0], raw[7]};
  endfunction

endpackage

// File: rtl/amiga_kbd_arbiter_fifo.sv
// Synchronous keycode FIFO with full/empty flags; a write is accepted while full
// when a read happens in the same cycle.
module kbd_code_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        wr_ok, rd_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/amiga_kbd_arbiter.sv
// Merges PS/2 and host keycodes into one queue and serialises them to the CIA
// with ack/timeout/retry handling. Optional power-up stream: AMIGA_KBD_POWERUP_EN.
module amiga_kbd_arbiter
  import amiga_kbd_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TX_TICKS    = 2816,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int RETRY_MAX   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic       ps2_strobe,
  input  logic [7:0] ps2_data,
  input  logic       host_strobe,
  input  logic [7:0] host_data,
  input  logic       keyboard_disabled,
  input  logic       keyack,
  output logic       key_strobe,
  output logic [7:0] key_data,
  output logic       busy,
  output logic       overflow,
  output logic       lost_sync
);

  localparam int TMAX_A = (TX_TICKS > ACK_TIMEOUT) ? TX_TICKS : ACK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > GAP_TICKS) ? TMAX_A : GAP_TICKS;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int RW     = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  logic       ps2_pend_q, host_pend_q, rr_host_q;
  logic [7:0] ps2_hold_q, host_hold_q;
  logic       take_ps2, take_host, xfer_valid, drop;
  logic       ps2_acc, host_acc;
  logic [7:0] xfer_data;
  logic       fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [7:0] fifo_head;

  kbd_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    cur_q, cur_d, key_data_q, key_data_d;
  logic          key_strobe_q, key_strobe_d, lost_sync_q, lost_sync_d;
  logic          ack_q, ack_d, ack_seen, overflow_q;

  assign ps2_acc    = ps2_strobe && !keyboard_disabled;
  assign host_acc   = host_strobe && !keyboard_disabled;
  // rr_host_q set means the host source wins the next tie.
  assign take_ps2   = ps2_pend_q && (!host_pend_q || !rr_host_q);
  assign take_host  = host_pend_q && !take_ps2;
  assign xfer_valid = take_ps2 || take_host;
  assign xfer_data  = take_ps2 ? ps2_hold_q : host_hold_q;
  assign fifo_wr    = xfer_valid && (!fifo_full || fifo_rd);
  assign drop       = xfer_valid && fifo_full && !fifo_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2_pend_q  <= 1'b0;
      host_pend_q <= 1'b0;
      ps2_hold_q  <= 8'h00;
      host_hold_q <= 8'h00;
      rr_host_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ps2_pend_q  <= (ps2_pend_q && !take_ps2) || ps2_acc;
      host_pend_q <= (host_pend_q && !take_host) || host_acc;
      if (ps2_acc)  ps2_hold_q  <= ps2_data;
      if (host_acc) host_hold_q <= host_data;
      if (take_ps2)       rr_host_q <= 1'b1;
      else if (take_host) rr_host_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
    end
  end

  kbd_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (xfer_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef AMIGA_KBD_POWERUP_EN
  localparam logic [1:0] PU_DONE = 2'd2;
  logic [1:0] pu_q, pu_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pu_q <= 2'd0;
    else          pu_q <= pu_d;
  end
`endif

  // A keyack pulse between ticks is held until the next WAIT_ACK tick consumes it.
  assign ack_seen = ack_q || keyack;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    cur_d        = cur_q;
    key_data_d   = key_data_q;
    key_strobe_d = key_strobe_q;
    lost_sync_d  = lost_sync_q;
    fifo_rd      = 1'b0;
    ack_d        = (state_q == ST_WAIT_ACK) && ack_seen && !clk7_en;
`ifdef AMIGA_KBD_POWERUP_EN
    pu_d         = pu_q;
`endif
    if (clk7_en) begin
      key_strobe_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
`ifdef AMIGA_KBD_POWERUP_EN
          if (pu_q != PU_DONE) begin
            cur_d   = (pu_q == 2'd0) ? KBD_CODE_INIT : KBD_CODE_TERM;
            pu_d    = pu_q + 2'd1;
            retry_d = '0;
            state_d = ST_LOAD;
          end else
`endif
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            cur_d   = fifo_head;
            retry_d = '0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          key_strobe_d = 1'b1;
          key_data_d   = kbd_encode(cur_q);
          timer_d      = TW'(TX_TICKS - 1);
          state_d      = ST_SEND;
        end
        ST_SEND: begin
          if (timer_q == '0) begin
            timer_d = TW'(ACK_TIMEOUT - 1);
            state_d = ST_WAIT_ACK;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_seen) begin
            timer_d = TW'(GAP_TICKS - 1);
            state_d = ST_GAP;
          end else if (timer_q == '0) begin
            if (retry_q < RW'(RETRY_MAX)) begin
              retry_d = retry_q + RW'(1);
              state_d = ST_LOAD;
            end else begin
              lost_sync_d = 1'b1;
              timer_d     = TW'(GAP_TICKS - 1);
              state_d     = ST_GAP;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_q == '0) state_d = ST_IDLE;
          else               timer_d = timer_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      cur_q        <= 8'h00;
      key_data_q   <= 8'h00;
      key_strobe_q <= 1'b0;
      lost_sync_q  <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      cur_q        <= cur_d;
      key_data_q   <= key_data_d;
      key_strobe_q <= key_strobe_d;
      lost_sync_q  <= lost_sync_d;
      ack_q        <= ack_d;
    end
  end

  assign key_strobe = key_strobe_q;
  assign key_data   = key_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = overflow_q;
  assign lost_sync  = lost_sync_q;

endmodule
